// File: rtl/acia_tx_responder_if.sv
// ============================================================================
// Module      : acia_tx_responder_if
// Description : 6502 bus window of the ACIA slot (strobes, data, irq).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface acia_tx_responder_if;
   logic       phi2;
   logic       cs_n;
   logic       rw;
   logic [1:0] rs;
   logic [7:0] d_in;
   logic [7:0] d_out;
   logic       d_oe;
   logic       irq_n;

   // CPU / decoder side
   modport master (
      output phi2, cs_n, rw, rs, d_in,
      input  d_out, d_oe, irq_n
   );

   // Responder side
   modport slave (
      input  phi2, cs_n, rw, rs, d_in,
      output d_out, d_oe, irq_n
   );
endinterface

`default_nettype wire

// File: rtl/acia_tx_responder.sv
// ============================================================================
// Module      : acia_tx_responder
// Description : 6551-style register window on the ACIA chip-select slot with
//               a transmit-only 8N1 UART. Bus strobes are sampled in clk.
// Options     : ACIA_IRQ_EN - when defined, irq_n and status bit 7 are live;
//               otherwise irq_n is tied high and status bit 7 reads 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module acia_tx_responder #(
   parameter int unsigned CLK_DIV = 16,
   parameter int unsigned DIV_W   = 16
) (
   input  wire logic           clk,
   input  wire logic           reset_n,
   acia_tx_responder_if.slave  bus,
   output logic                txd,
   output logic                busy
);

   localparam logic [DIV_W-1:0] c_bit_last = DIV_W'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } tx_state_t;

   // bus sampling
   logic       r_phi2_m, r_phi2_s, r_phi2_s_d;
   logic       r_cap_cs_n, r_cap_rw;
   logic [1:0] r_cap_rs;
   logic [7:0] r_cap_d;

   // registers
   logic [7:0] r_thr, r_cmd, r_ctrl;
   logic       r_thr_full, r_ovr;

   // transmitter
   tx_state_t        r_state, w_state_nx;
   logic [DIV_W-1:0] r_cnt, w_cnt_nx;
   logic [2:0]       r_idx, w_idx_nx;
   logic [7:0]       r_shift, w_shift_nx;
   logic             r_txd, w_txd_nx;
   logic             r_busy, w_busy_nx;
   logic             w_load, w_bit_end, w_can_load;

   logic w_commit, w_wr, w_rd;
   logic w_thr_wr, w_preset, w_cmd_wr, w_ctrl_wr, w_stat_rd;
   logic w_irq;
   logic [7:0] w_status;

   // A bus access commits on the single clk where the synchronised phi2 falls.
   assign w_commit  = r_phi2_s_d & ~r_phi2_s & ~r_cap_cs_n;
   assign w_wr      = w_commit & ~r_cap_rw;
   assign w_rd      = w_commit &  r_cap_rw;
   assign w_thr_wr  = w_wr & (r_cap_rs == 2'd0);
   assign w_preset  = w_wr & (r_cap_rs == 2'd1);
   assign w_cmd_wr  = w_wr & (r_cap_rs == 2'd2);
   assign w_ctrl_wr = w_wr & (r_cap_rs == 2'd3);
   assign w_stat_rd = w_rd & (r_cap_rs == 2'd1);

   // Synchronise phi2 and latch the strobes while it is high
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_phi2_m   <= 1'b0;
         r_phi2_s   <= 1'b0;
         r_phi2_s_d <= 1'b0;
         r_cap_cs_n <= 1'b1;
         r_cap_rw   <= 1'b1;
         r_cap_rs   <= 2'd0;
         r_cap_d    <= 8'h00;
      end else begin
         r_phi2_m   <= bus.phi2;
         r_phi2_s   <= r_phi2_m;
         r_phi2_s_d <= r_phi2_s;
         if (r_phi2_s) begin
            r_cap_cs_n <= bus.cs_n;
            r_cap_rw   <= bus.rw;
            r_cap_rs   <= bus.rs;
            r_cap_d    <= bus.d_in;
         end
      end
   end

   // Register file: THR/overrun tracking, command and control storage
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_thr      <= 8'h00;
         r_thr_full <= 1'b0;
         r_ovr      <= 1'b0;
         r_cmd      <= 8'h00;
         r_ctrl     <= 8'h00;
      end else begin
         if (w_thr_wr) begin
            r_thr      <= r_cap_d;
            r_thr_full <= 1'b1;
         end else if (w_load) begin
            r_thr_full <= 1'b0;
         end
         // A write racing the shifter load is not an overrun: the old byte left.
         if (w_preset || w_stat_rd)
            r_ovr <= 1'b0;
         else if (w_thr_wr && r_thr_full && !w_load)
            r_ovr <= 1'b1;
         if (w_preset)
            r_cmd <= 8'h00;
         else if (w_cmd_wr)
            r_cmd <= r_cap_d;
         if (w_ctrl_wr)
            r_ctrl <= r_cap_d;
      end
   end

   assign w_can_load = r_thr_full & r_cmd[0];
   assign w_bit_end  = (r_cnt == c_bit_last);

   // Transmitter state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= 3'd0;
         r_shift <= 8'h00;
         r_txd   <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_idx   <= w_idx_nx;
         r_shift <= w_shift_nx;
         r_txd   <= w_txd_nx;
         r_busy  <= w_busy_nx;
      end
   end

   // Transmitter next state; the stop bit can reload directly into a start bit
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt + 1'b1;
      w_idx_nx   = r_idx;
      w_shift_nx = r_shift;
      w_txd_nx   = r_txd;
      w_busy_nx  = r_busy;
      w_load     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_nx = '0;
            if (w_can_load) begin
               w_load     = 1'b1;
               w_shift_nx = r_thr;
               w_state_nx = S_START;
               w_txd_nx   = 1'b0;
               w_busy_nx  = 1'b1;
            end
         end
         S_START: begin
            if (w_bit_end) begin
               w_cnt_nx   = '0;
               w_idx_nx   = 3'd0;
               w_state_nx = S_DATA;
               w_txd_nx   = r_shift[0];
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               w_cnt_nx   = '0;
               w_shift_nx = {1'b0, r_shift[7:1]};
               if (r_idx == 3'd7) begin
                  w_state_nx = S_STOP;
                  w_txd_nx   = 1'b1;
               end else begin
                  w_idx_nx = r_idx + 3'd1;
                  w_txd_nx = r_shift[1];
               end
            end
         end
         S_STOP: begin
            if (w_bit_end) begin
               w_cnt_nx = '0;
               if (w_can_load) begin
                  w_load     = 1'b1;
                  w_shift_nx = r_thr;
                  w_state_nx = S_START;
                  w_txd_nx   = 1'b0;
               end else begin
                  w_state_nx = S_IDLE;
                  w_busy_nx  = 1'b0;
               end
            end
         end
         default: begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
            w_txd_nx   = 1'b1;
            w_busy_nx  = 1'b0;
         end
      endcase
   end

   assign txd  = r_txd;
   assign busy = r_busy;

`ifdef ACIA_IRQ_EN
   logic r_irq_n;

   assign w_irq = ~r_thr_full & (r_cmd[3:2] == 2'b01);

   // Interrupt output follows its cause one clk later
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_irq_n <= 1'b1;
      else
         r_irq_n <= ~w_irq;
   end

   assign bus.irq_n = r_irq_n;
`else
   assign w_irq     = 1'b0;
   assign bus.irq_n = 1'b1;
`endif

   assign w_status = {w_irq, 2'b00, ~r_thr_full, 1'b0, r_ovr, 2'b00};

   // Read data is refreshed every clk from the register currently addressed
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.d_out <= 8'h00;
      end else begin
         case (bus.rs)
            2'd0:    bus.d_out <= 8'h00;
            2'd1:    bus.d_out <= w_status;
            2'd2:    bus.d_out <= r_cmd;
            default: bus.d_out <= r_ctrl;
         endcase
      end
   end

   assign bus.d_oe = ~bus.cs_n & bus.rw & bus.phi2;

endmodule

`default_nettype wire

// File: tb/tb_acia_tx_responder.sv
// ============================================================================
// Module      : tb_acia_tx_responder
// Description : Directed self-checking bench for acia_tx_responder (CLK_DIV=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_acia_tx_responder;

   localparam int CLK_DIV = 4;
   localparam int BIT_CLKS = CLK_DIV;
   localparam int FRAME_CLKS = 10 * CLK_DIV;
`ifdef ACIA_IRQ_EN
   localparam bit IRQ_ON = 1'b1;
`else
   localparam bit IRQ_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic txd, busy;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] rdv;
   logic       oe;

   acia_tx_responder_if bus();

   acia_tx_responder #(
      .CLK_DIV (CLK_DIV),
      .DIV_W   (16)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus),
      .txd     (txd),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   // Single comparison point
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
      end
   endtask

   // One 6502 bus cycle: phi2 high 4 clks, address/data held 4 clks past the fall
   task automatic bus_cycle(input logic rw, input logic [1:0] rs, input logic [7:0] d,
                            output logic [7:0] rd, output logic d_oe_s);
      @(posedge clk); #1;
      bus.cs_n = 1'b0; bus.rw = rw; bus.rs = rs; bus.d_in = d; bus.phi2 = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rd     = bus.d_out;
      d_oe_s = bus.d_oe;
      @(posedge clk); #1;
      bus.phi2 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      bus.cs_n = 1'b1; bus.rw = 1'b1;
   endtask

   task automatic wr(input logic [1:0] rs, input logic [7:0] d);
      logic [7:0] dummy;
      logic       dummy_oe;
      bus_cycle(1'b0, rs, d, dummy, dummy_oe);
   endtask

   task automatic rd(input logic [1:0] rs, output logic [7:0] v);
      logic dummy_oe;
      bus_cycle(1'b1, rs, 8'h00, v, dummy_oe);
   endtask

   function automatic logic frame_bit(input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i == 9) return 1'b1;
      return b[i-1];
   endfunction

   // Bounded wait for a start bit, sampled on the falling clk edge
   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (txd === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      chk("start bit seen", {7'b0, ok}, 8'h01);
   endtask

   // Check n back-to-back frames clk by clk, then the idle line after them
   task automatic check_frames(input int n, input logic [7:0] b0, input logic [7:0] b1);
      bit ok;
      logic [7:0] b;
      wait_start(ok);
      if (ok) begin
         for (int i = 0; i < n * FRAME_CLKS; i++) begin
            if (i > 0) @(negedge clk);
            b = (i < FRAME_CLKS) ? b0 : b1;
            chk($sformatf("txd frame%0d bit%0d clk%0d", i / FRAME_CLKS,
                          (i % FRAME_CLKS) / BIT_CLKS, i % BIT_CLKS),
                {7'b0, txd}, {7'b0, frame_bit(b, (i % FRAME_CLKS) / BIT_CLKS)});
            if ((i % BIT_CLKS) == 0)
               chk("busy in frame", {7'b0, busy}, 8'h01);
         end
         @(negedge clk);
         chk("txd idle after frame", {7'b0, txd}, 8'h01);
         chk("busy low after frame", {7'b0, busy}, 8'h00);
      end
   endtask

   // Catches a run that never finishes
   initial begin
      #1_000_000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      bus.phi2 = 1'b0; bus.cs_n = 1'b1; bus.rw = 1'b1; bus.rs = 2'd0; bus.d_in = 8'h00;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset txd",   {7'b0, txd},       8'h01);
      chk("reset busy",  {7'b0, busy},      8'h00);
      chk("reset irq_n", {7'b0, bus.irq_n}, 8'h01);
      chk("reset d_out", bus.d_out,         8'h00);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);

      // 1: status after reset, read drives d_oe
      bus_cycle(1'b1, 2'd1, 8'h00, rdv, oe);
      chk("status after reset", rdv, 8'h10);
      chk("d_oe on read",       {7'b0, oe}, 8'h01);
      chk("idle txd",           {7'b0, txd}, 8'h01);

      // 2: single frame 0x55; TDRE is back while the frame is on the wire
      wr(2'd2, 8'h01);
      rd(2'd2, rdv);
      chk("cmd readback", rdv, 8'h01);
      fork
         check_frames(1, 8'h55, 8'h00);
         begin
            wr(2'd0, 8'h55);
            rd(2'd1, rdv);
            chk("TDRE during frame", rdv, 8'h10);
         end
      join

      // 3: second byte written mid-frame chains without a gap
      fork
         check_frames(2, 8'hA5, 8'h3C);
         begin
            wr(2'd0, 8'hA5);
            wr(2'd0, 8'h3C);
         end
      join

      // 4: overrun, last write wins; status read clears OVR
      fork
         check_frames(2, 8'h11, 8'h33);
         begin
            wr(2'd0, 8'h11);
            wr(2'd0, 8'h22);
            wr(2'd0, 8'h33);
         end
      join
      rd(2'd1, rdv);
      chk("status with OVR", rdv, 8'h14);
      rd(2'd1, rdv);
      chk("status OVR cleared", rdv, 8'h10);

      // 5: interrupt on empty THR
      wr(2'd2, 8'h05);
      chk("irq_n THR empty", {7'b0, bus.irq_n}, IRQ_ON ? 8'h00 : 8'h01);
      rd(2'd1, rdv);
      chk("status with IRQ", rdv, IRQ_ON ? 8'h90 : 8'h10);
      wr(2'd2, 8'h04);
      wr(2'd0, 8'hC3);
      chk("irq_n THR full", {7'b0, bus.irq_n}, 8'h01);
      repeat (20) @(negedge clk);
      chk("irq_n held",         {7'b0, bus.irq_n}, 8'h01);
      chk("no tx while disabled", {7'b0, busy},    8'h00);
      fork
         wr(2'd2, 8'h05);
         check_frames(1, 8'hC3, 8'h00);
         begin
            wait_start(ok);
            chk("irq_n at load clk", {7'b0, bus.irq_n}, 8'h01);
            @(negedge clk);
            chk("irq_n after load", {7'b0, bus.irq_n}, IRQ_ON ? 8'h00 : 8'h01);
         end
      join

      // Control storage and programmed reset
      wr(2'd2, 8'h0D);
      rd(2'd2, rdv);
      chk("cmd 0x0D", rdv, 8'h0D);
      wr(2'd3, 8'hA7);
      wr(2'd1, 8'h00);
      rd(2'd2, rdv);
      chk("cmd after programmed reset", rdv, 8'h00);
      rd(2'd3, rdv);
      chk("ctrl survives programmed reset", rdv, 8'hA7);
      chk("irq_n after programmed reset", {7'b0, bus.irq_n}, 8'h01);

      // 6: hardware reset during data bit 3 of 0x96 (bit 3 is a 0)
      wr(2'd2, 8'h01);
      wr(2'd0, 8'h96);
      wait_start(ok);
      repeat (17) @(negedge clk);
      chk("txd in data bit3", {7'b0, txd}, 8'h00);
      #2;
      reset_n = 1'b0;
      #1;
      chk("txd async reset",  {7'b0, txd},  8'h01);
      chk("busy async reset", {7'b0, busy}, 8'h00);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      rd(2'd1, rdv);
      chk("status after mid-frame reset", rdv, 8'h10);
      repeat (2 * FRAME_CLKS) @(negedge clk);
      chk("no frame resume", {7'b0, busy}, 8'h00);
      wr(2'd2, 8'h01);
      fork
         check_frames(1, 8'h69, 8'h00);
         wr(2'd0, 8'h69);
      join

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
